vdiv_unit: RTL and testbench

Iterative SIMD integer divider for the vector execution stage, sitting beside the pipelined vector multiplier and sharing its 64-bit packed-lane datapath and `sew_t` encoding. It computes `vdiv`, `vdivu`, `vrem` and `vremu` on 8×8, 4×16, 2×32 or 1×64-bit lanes. All lanes run in parallel using a radix-2 restoring algorithm, one quotient bit per cycle. Operations are handed in and out with a single-outstanding valid/ready handshake.

---
 rtl/vdiv_unit.sv | 212 +++++++++++++++++++++
 tb/tb_vdiv_unit.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdiv_unit.sv
// -----------------------------------------------------------------------------
// vdiv_unit - iterative SIMD integer divider (vdiv / vdivu / vrem / vremu).
//
// One radix-2 restoring step per cycle. The step is applied to all lanes of
// the selected element width (8x8, 4x16, 2x32 or 1x64 bits) in parallel.
// A single operation is in flight at a time, with a valid/ready handshake.
//
// Ports
//   clk_i         clock
//   rst_i         synchronous active-high reset (also clears data_vd_o)
//   valid_i       request; accepted on a rising edge while ready_o=1
//   ready_o       unit idle
//   kill_i        flush: abort any in-flight op, drop a simultaneous request
//   instr_type_i  3'd0 VDIV, 3'd1 VDIVU, 3'd2 VREM, 3'd3 VREMU
//   sew_i         3'd0 SEW_8, 3'd1 SEW_16, 3'd2 SEW_32, 3'd3 SEW_64
//   data_vs2_i    dividend lanes
//   data_vs1_i    divisor lanes
//   valid_o       one-cycle result strobe
//   data_vd_o     quotient/remainder lanes; held until the next result
//
// Unsupported opcode/SEW encodings run with SEW_64 latency and return zero.
//
// Optional feature, macro VDIV_ZERO_EARLY_OUT_EN: when every divisor lane is
// zero at acceptance, the divide phase is skipped (latency 2 for any SEW).
// -----------------------------------------------------------------------------
module vdiv_unit (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic        kill_i,
   input  logic [2:0]  instr_type_i,
   input  logic [2:0]  sew_i,
   input  logic [63:0] data_vs2_i,
   input  logic [63:0] data_vs1_i,
   output logic        valid_o,
   output logic [63:0] data_vd_o
);

   localparam logic [2:0] VDIV  = 3'd0;
   localparam logic [2:0] VDIVU = 3'd1;
   localparam logic [2:0] VREM  = 3'd2;
   localparam logic [2:0] VREMU = 3'd3;

   typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_FIXUP, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [6:0]  cnt_q, cnt_d;
   logic [1:0]  sidx_q, sidx_d;       // lane-width index: 0..3 -> 8..64 bits
   logic        bad_q, bad_d;         // unsupported opcode or SEW
   logic        sgn_q, sgn_d;         // signed operation
   logic        rem_sel_q, rem_sel_d; // return remainder instead of quotient
   logic [63:0] a_q, a_d;             // original dividend (signs, special cases)
   logic [63:0] b_q, b_d;             // original divisor
   logic [63:0] dvs_q, dvs_d;         // divisor magnitudes
   logic [63:0] rem_q, rem_d;         // partial remainders
   logic [63:0] quo_q, quo_d;         // dividend bits shifting out, quotient in
   logic [63:0] data_q, data_d;

   // Request decode
   logic       in_bad, in_signed, early_out;
   logic [1:0] in_sidx;

   always_comb begin
      in_bad    = (sew_i > 3'd3) || (instr_type_i > VREMU);
      in_sidx   = in_bad ? 2'd3 : sew_i[1:0];
      in_signed = (instr_type_i == VDIV) || (instr_type_i == VREM);
   end

   // Per-width lane logic; the FSM selects one width with sidx.
   logic [3:0][63:0] abs_a_w, abs_b_w, step_rem_w, step_quo_w, fix_res_w;
`ifdef VDIV_ZERO_EARLY_OUT_EN
   logic [3:0]       all_zero_w;
`endif

   for (genvar gw = 0; gw < 4; gw++) begin : g_w
      localparam int W = 8 << gw;
      localparam int N = 64 / W;
`ifdef VDIV_ZERO_EARLY_OUT_EN
      logic [N-1:0] lane_zero;
      assign all_zero_w[gw] = &lane_zero;
`endif
      for (genvar gi = 0; gi < N; gi++) begin : g_l
         localparam int LO = gi * W;
         logic [W-1:0] a_in, b_in, a_l, b_l, q_n, r_n, q_f, r_f;
         logic [W:0]   trial, diff;
         logic         go, b_zero, ovf;

         // Magnitudes at acceptance (two's-complement negation within lane)
         assign a_in = data_vs2_i[LO +: W];
         assign b_in = data_vs1_i[LO +: W];
         assign abs_a_w[gw][LO +: W] = (in_signed && a_in[W-1]) ? -a_in : a_in;
         assign abs_b_w[gw][LO +: W] = (in_signed && b_in[W-1]) ? -b_in : b_in;
`ifdef VDIV_ZERO_EARLY_OUT_EN
         assign lane_zero[gi] = (b_in == '0);
`endif

         // Restoring step: the partial remainder is widened by one bit so
         // the trial subtraction borrow doubles as the quotient bit.
         assign trial = {rem_q[LO +: W], quo_q[LO + W - 1]};
         assign diff  = trial - {1'b0, dvs_q[LO +: W]};
         assign go    = ~diff[W];
         assign step_rem_w[gw][LO +: W] = go ? diff[W-1:0] : trial[W-1:0];
         assign step_quo_w[gw][LO +: W] = {quo_q[LO +: W-1], go};

         // Sign restore and RVV special cases
         assign a_l    = a_q[LO +: W];
         assign b_l    = b_q[LO +: W];
         assign q_n    = (sgn_q && (a_l[W-1] ^ b_l[W-1])) ? -quo_q[LO +: W]
                                                         :  quo_q[LO +: W];
         assign r_n    = (sgn_q && a_l[W-1]) ? -rem_q[LO +: W] : rem_q[LO +: W];
         assign b_zero = (b_l == '0);
         assign ovf    = sgn_q && (a_l == {1'b1, {(W-1){1'b0}}}) && (b_l == '1);
         assign q_f    = b_zero ? '1  : (ovf ? a_l : q_n);
         assign r_f    = b_zero ? a_l : (ovf ? '0  : r_n);
         assign fix_res_w[gw][LO +: W] = rem_sel_q ? r_f : q_f;
      end
   end

`ifdef VDIV_ZERO_EARLY_OUT_EN
   assign early_out = !in_bad && all_zero_w[in_sidx];
`else
   assign early_out = 1'b0;
`endif

   // Next-state and datapath control
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sidx_d    = sidx_q;
      bad_d     = bad_q;
      sgn_d     = sgn_q;
      rem_sel_d = rem_sel_q;
      a_d       = a_q;
      b_d       = b_q;
      dvs_d     = dvs_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      data_d    = data_q;
      if (kill_i) begin
         // Flush wins over everything, including a request in IDLE.
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (valid_i) begin
                  sidx_d    = in_sidx;
                  bad_d     = in_bad;
                  sgn_d     = in_signed;
                  rem_sel_d = (instr_type_i == VREM) || (instr_type_i == VREMU);
                  a_d       = data_vs2_i;
                  b_d       = data_vs1_i;
                  quo_d     = abs_a_w[in_sidx];
                  dvs_d     = abs_b_w[in_sidx];
                  rem_d     = '0;
                  cnt_d     = 7'd8 << in_sidx;
                  state_d   = early_out ? S_FIXUP : S_DIVIDE;
               end
            end
            S_DIVIDE: begin
               rem_d = step_rem_w[sidx_q];
               quo_d = step_quo_w[sidx_q];
               cnt_d = cnt_q - 7'd1;
               if (cnt_q == 7'd1) begin
                  state_d = S_FIXUP;
               end
            end
            S_FIXUP: begin
               data_d  = bad_q ? '0 : fix_res_w[sidx_q];
               state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         sidx_q    <= '0;
         bad_q     <= 1'b0;
         sgn_q     <= 1'b0;
         rem_sel_q <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         dvs_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sidx_q    <= sidx_d;
         bad_q     <= bad_d;
         sgn_q     <= sgn_d;
         rem_sel_q <= rem_sel_d;
         a_q       <= a_d;
         b_q       <= b_d;
         dvs_q     <= dvs_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         data_q    <= data_d;
      end
   end

   assign ready_o   = (state_q == S_IDLE);
   assign valid_o   = (state_q == S_DONE);
   assign data_vd_o = data_q;

endmodule

// File: tb/tb_vdiv_unit.sv
// -----------------------------------------------------------------------------
// tb_vdiv_unit - self-checking bench for vdiv_unit.
// Expected results and due cycles are queued at acceptance; a monitor pops
// and compares them when valid_o strobes. Scenario tasks check handshake,
// kill and reset behaviour inline.
// -----------------------------------------------------------------------------
module tb_vdiv_unit;

   localparam logic [2:0] SEW_8  = 3'd0;
   localparam logic [2:0] SEW_16 = 3'd1;
   localparam logic [2:0] SEW_32 = 3'd2;
   localparam logic [2:0] SEW_64 = 3'd3;
   localparam logic [2:0] VDIV   = 3'd0;
   localparam logic [2:0] VDIVU  = 3'd1;
   localparam logic [2:0] VREM   = 3'd2;
   localparam logic [2:0] VREMU  = 3'd3;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        valid_i = 1'b0;
   logic        kill_i = 1'b0;
   logic [2:0]  instr_type_i = '0;
   logic [2:0]  sew_i = '0;
   logic [63:0] data_vs2_i = '0;
   logic [63:0] data_vs1_i = '0;
   logic        ready_o, valid_o;
   logic [63:0] data_vd_o;

   vdiv_unit dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .valid_i      (valid_i),
      .ready_o      (ready_o),
      .kill_i       (kill_i),
      .instr_type_i (instr_type_i),
      .sew_i        (sew_i),
      .data_vs2_i   (data_vs2_i),
      .data_vs1_i   (data_vs1_i),
      .valid_o      (valid_o),
      .data_vd_o    (data_vd_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] data;
      int          due;
      string       name;
   } exp_t;

   exp_t scb[$];
   int   checks = 0;
   int   errors = 0;

   // ---------------- reference model ----------------
   function automatic logic [63:0] ref_calc(input logic [2:0] op, input logic [2:0] sew,
                                            input logic [63:0] a, input logic [63:0] b);
      logic [63:0] res, mask, ua, ub, q, r, mn;
      longint      sa, sbv;
      int          w;
      bit          sgn, rem;
      if (sew > 3'd3 || op > 3'd3) return 64'd0;
      w    = 8 << sew;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      mn   = 64'd1 << (w - 1);
      sgn  = (op == VDIV) || (op == VREM);
      rem  = (op == VREM) || (op == VREMU);
      res  = '0;
      for (int i = 0; i < 64 / w; i++) begin
         ua  = (a >> (i * w)) & mask;
         ub  = (b >> (i * w)) & mask;
         sa  = longint'(ua << (64 - w)) >>> (64 - w);
         sbv = longint'(ub << (64 - w)) >>> (64 - w);
         if (ub == 0) begin
            q = mask; r = ua;
         end else if (sgn && ua == mn && ub == mask) begin
            q = ua; r = 0;
         end else if (sgn) begin
            q = 64'(sa / sbv) & mask;
            r = 64'(sa % sbv) & mask;
         end else begin
            q = ua / ub;
            r = ua % ub;
         end
         res = res | (((rem ? r : q) & mask) << (i * w));
      end
      return res;
   endfunction

   function automatic int lat(input logic [2:0] op, input logic [2:0] sew, input logic [63:0] b);
      bit bad;
      bad = (sew > 3'd3) || (op > 3'd3);
      if (bad) return 66;
`ifdef VDIV_ZERO_EARLY_OUT_EN
      if (b == 64'd0) return 2;
`else
      if (b == 64'd0) return (8 << sew) + 2;
`endif
      return (8 << sew) + 2;
   endfunction

   function automatic logic [63:0] gen_operand(input logic [2:0] sew);
      logic [63:0] v, lane, mask;
      int          w;
      w    = (sew > 3'd3) ? 64 : (8 << sew);
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      v    = '0;
      for (int i = 0; i < 64 / w; i++) begin
         case ($urandom_range(0, 7))
            0:       lane = '0;
            1:       lane = mask;
            2:       lane = 64'd1 << (w - 1);
            3:       lane = mask >> 1;
            4:       lane = 64'd1;
            default: lane = {$urandom, $urandom} & mask;
         endcase
         v = v | (lane << (i * w));
      end
      return v;
   endfunction

   // ---------------- result monitor ----------------
   always @(negedge clk_i) begin
      exp_t e;
      if (valid_o === 1'b1) begin
         checks++;
         if (scb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe: valid_o=1 at cycle %0d, required 0", cyc);
         end else begin
            e = scb.pop_front();
            if (data_vd_o !== e.data) begin
               errors++;
               $display("FAIL %s data: got %h required %h", e.name, data_vd_o, e.data);
            end
            checks++;
            if (cyc != e.due) begin
               errors++;
               $display("FAIL %s latency: strobe at cycle %0d required %0d", e.name, cyc, e.due);
            end else begin
               $display("op %s result %h at cycle %0d", e.name, data_vd_o, cyc);
            end
         end
      end else if (scb.size() != 0 && cyc > scb[0].due) begin
         checks++;
         errors++;
         $display("FAIL %s missing_strobe: no valid_o by cycle %0d, required at %0d",
                  scb[0].name, cyc, scb[0].due);
         void'(scb.pop_front());
      end
   end

   // ---------------- driver helpers ----------------
   // Presents a request, waits for acceptance, optionally queues the expectation.
   task automatic issue(input logic [2:0] op, input logic [2:0] sew,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input bit track, input string name);
      int n;
      bit rdy;
      exp_t e;
      @(negedge clk_i);
      instr_type_i = op;
      sew_i        = sew;
      data_vs2_i   = a;
      data_vs1_i   = b;
      valid_i      = 1'b1;
      n   = 0;
      rdy = ready_o;
      while (!rdy && n < 300) begin
         @(negedge clk_i);
         rdy = ready_o;
         n++;
      end
      if (!rdy) begin
         checks++;
         errors++;
         $display("FAIL %s accept: ready_o stayed 0 for %0d cycles, required 1", name, n);
         valid_i = 1'b0;
         return;
      end
      @(posedge clk_i);
      @(negedge clk_i);
      valid_i = 1'b0;
      if (track) begin
         e.data = exp;
         e.due  = cyc + lat(op, sew, b) - 1;
         e.name = name;
         scb.push_back(e);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (scb.size() != 0 && n < 300) begin
         @(negedge clk_i);
         n++;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_i = 1'b1;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      checks++;
      if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", ready_o); end
      checks++;
      if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", valid_o); end
      checks++;
      if (data_vd_o !== 64'd0) begin errors++; $display("FAIL reset_data: got %h required 0", data_vd_o); end
      rst_i = 1'b0;
   endtask

   task automatic test_directed();
      issue(VDIV,  SEW_8,  64'hF9F9F9F9F9F9F9F9, 64'h0202020202020202, 64'hFDFDFDFDFDFDFDFD, 1, "div8");
      drain();
      issue(VREM,  SEW_8,  64'hF9F9F9F9F9F9F9F9, 64'h0202020202020202, 64'hFFFFFFFFFFFFFFFF, 1, "rem8");
      drain();
      issue(VDIVU, SEW_16, 64'h0000000000001234, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1, "divu16_z");
      drain();
      issue(VREMU, SEW_16, 64'h0000000000001234, 64'd0, 64'h0000000000001234, 1, "remu16_z");
      drain();
      issue(VDIV,  SEW_32, 64'h8000000080000000, 64'hFFFFFFFF00000003, 64'h80000000D5555556, 1, "div32_ovf");
      drain();
      issue(VREM,  SEW_32, 64'h8000000080000000, 64'hFFFFFFFF00000003, 64'h00000000FFFFFFFE, 1, "rem32_ovf");
      drain();
   endtask

   task automatic test_unsupported();
      issue(VDIV, 3'd5, 64'h0123456789ABCDEF, 64'h0000000000000003, 64'd0, 1, "bad_sew");
      drain();
      issue(3'd6, SEW_8, 64'h0123456789ABCDEF, 64'h0101010101010101, 64'd0, 1, "bad_op");
      drain();
   endtask

   task automatic test_back_to_back();
      int   n, e0;
      exp_t e;
      issue(VREMU, SEW_64, 64'd100, 64'd7, 64'd2, 1, "remu64");
      e0 = cyc;
      // hold a second request through the busy window
      instr_type_i = VDIV;
      sew_i        = SEW_8;
      data_vs2_i   = 64'hF9F9F9F9F9F9F9F9;
      data_vs1_i   = 64'h0202020202020202;
      valid_i      = 1'b1;
      n = 0;
      while (!ready_o && n < 200) begin
         n++;
         @(negedge clk_i);
      end
      checks++;
      if (n != 66) begin errors++; $display("FAIL busy_window: ready_o low for %0d cycles required 66", n); end
      @(posedge clk_i);
      @(negedge clk_i);
      valid_i = 1'b0;
      checks++;
      if (cyc != e0 + 67) begin
         errors++;
         $display("FAIL held_accept: accepted at edge %0d required %0d", cyc, e0 + 67);
      end
      e.data = 64'hFDFDFDFDFDFDFDFD;
      e.due  = cyc + 9;
      e.name = "div8_held";
      scb.push_back(e);
      drain();
   endtask

   task automatic test_kill();
      // known result left in data_vd_o: 100 % 7 = 2
      issue(VREMU, SEW_64, 64'd100, 64'd7, 64'd2, 1, "remu64_pre");
      drain();
      issue(VDIV, SEW_32, 64'h0000006400000064, 64'h0000000700000007, 64'd0, 0, "killed32");
      repeat (4) @(negedge clk_i);
      kill_i = 1'b1;
      @(negedge clk_i);
      kill_i = 1'b0;
      checks++;
      if (ready_o !== 1'b1) begin errors++; $display("FAIL kill_ready: got %b required 1", ready_o); end
      checks++;
      if (valid_o !== 1'b0) begin errors++; $display("FAIL kill_valid: got %b required 0", valid_o); end
      checks++;
      if (data_vd_o !== 64'd2) begin errors++; $display("FAIL kill_data: got %h required %h", data_vd_o, 64'd2); end
      repeat (40) @(negedge clk_i);
      issue(VDIV, SEW_8, 64'hF9F9F9F9F9F9F9F9, 64'h0202020202020202, 64'hFDFDFDFDFDFDFDFD, 1, "div8_after_kill");
      drain();
      // kill beats a simultaneous request
      instr_type_i = VDIVU;
      sew_i        = SEW_8;
      data_vs2_i   = 64'h1111111111111111;
      data_vs1_i   = 64'h0303030303030303;
      valid_i      = 1'b1;
      kill_i       = 1'b1;
      @(negedge clk_i);
      valid_i = 1'b0;
      kill_i  = 1'b0;
      checks++;
      if (ready_o !== 1'b1) begin errors++; $display("FAIL kill_drop: ready_o=%b required 1", ready_o); end
      repeat (15) @(negedge clk_i);
      $display("kill scenarios complete at cycle %0d", cyc);
   endtask

   task automatic test_reset_mid();
      issue(VDIVU, SEW_16, 64'h1234123412341234, 64'h0011001100110011, 64'd0, 0, "reset16");
      repeat (4) @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      checks++;
      if (data_vd_o !== 64'd0) begin errors++; $display("FAIL rst_mid_data: got %h required 0", data_vd_o); end
      checks++;
      if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b required 0", valid_o); end
      checks++;
      if (ready_o !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b required 1", ready_o); end
      repeat (25) @(negedge clk_i);
      $display("mid-op reset complete at cycle %0d", cyc);
   endtask

   task automatic test_random();
      logic [2:0]  op, sew;
      logic [63:0] a, b;
      string       nm;
      for (int i = 0; i < 1000; i++) begin
         op  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
         sew = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
         a   = gen_operand(sew);
         b   = ($urandom_range(0, 19) == 0) ? 64'd0 : gen_operand(sew);
         nm  = $sformatf("rnd%0d_op%0d_sew%0d", i, op, sew);
         issue(op, sew, a, b, ref_calc(op, sew, a, b), 1, nm);
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_unsupported();
      test_back_to_back();
      test_kill();
      test_reset_mid();
      test_random();
      repeat (5) @(negedge clk_i);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
